// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : Synchronous instruction-memory read bus between the fetch unit
//            (master) and the instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface instr_fetch_unit_if #(
    parameter int ADDR_W = 10
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC owner and instruction fetch pipe; inserts bubbles while a BEQ
//            is unresolved and stops at HALT. Optional macro IFU_PERF_CNT_EN
//            adds saturating bubble / taken-branch counters.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module instr_fetch_unit #(
    parameter int                ADDR_W      = 10,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [5:0]        BEQ_OPCODE  = 6'b000100,
    parameter logic [5:0]        HALT_OPCODE = 6'b111111,
    parameter logic [31:0]       BUBBLE      = 32'hF800_0000
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              stall,
    instr_fetch_unit_if.master     imem,
    input  wire logic              branch_resolved,
    input  wire logic              PCSrc,
    input  wire logic [ADDR_W-1:0] branch_target,
    output logic [31:0]            instn,
    output logic                   instn_valid,
    output logic [ADDR_W-1:0]      instn_pc,
    output logic                   halted
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]            bubble_cnt,
    output logic [15:0]            br_taken_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t            r_state,      w_state;
    logic [ADDR_W-1:0] r_pc,         w_pc;
    logic              r_fetch_q,    w_fetch_q;
    logic [ADDR_W-1:0] r_fetch_pc_q, w_fetch_pc_q;
    logic [31:0]       r_instn,      w_instn;
    logic              r_valid,      w_valid;
    logic [ADDR_W-1:0] r_instn_pc,   w_instn_pc;
    logic              r_halted,     w_halted;
    logic              w_imem_en;
    logic [5:0]        w_cap_op;

    assign w_cap_op = imem.imem_rdata[31:26];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_fetch_q    <= 1'b0;
            r_fetch_pc_q <= '0;
            r_instn      <= BUBBLE;
            r_valid      <= 1'b0;
            r_instn_pc   <= '0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_fetch_q    <= w_fetch_q;
            r_fetch_pc_q <= w_fetch_pc_q;
            r_instn      <= w_instn;
            r_valid      <= w_valid;
            r_instn_pc   <= w_instn_pc;
            r_halted     <= w_halted;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_pc         = r_pc;
        w_fetch_q    = r_fetch_q;
        w_fetch_pc_q = r_fetch_pc_q;
        w_instn      = r_instn;
        w_valid      = r_valid;
        w_instn_pc   = r_instn_pc;
        w_halted     = r_halted;
        w_imem_en    = 1'b0;

        case (r_state)
            ST_FETCH: begin
                if (!stall) begin
                    w_imem_en    = 1'b1;
                    w_pc         = r_pc + ADDR_W'(1);
                    w_fetch_q    = 1'b1;
                    w_fetch_pc_q = r_pc;
                    if (r_fetch_q) begin
                        w_instn    = imem.imem_rdata;
                        w_valid    = 1'b1;
                        w_instn_pc = r_fetch_pc_q;
                        // The word fetched alongside a BEQ is speculative; drop it and rewind.
                        if (w_cap_op == BEQ_OPCODE) begin
                            w_state   = ST_BR_WAIT;
                            w_pc      = r_fetch_pc_q + ADDR_W'(1);
                            w_fetch_q = 1'b0;
                        end else if (w_cap_op == HALT_OPCODE) begin
                            w_instn   = BUBBLE;
                            w_valid   = 1'b0;
                            w_state   = ST_HALT;
                            w_halted  = 1'b1;
                            w_fetch_q = 1'b0;
                        end
                    end else begin
                        w_instn = BUBBLE;
                        w_valid = 1'b0;
                    end
                end
            end
            ST_BR_WAIT: begin
                w_fetch_q = 1'b0;
                w_instn   = BUBBLE;
                w_valid   = 1'b0;
                if (branch_resolved) begin
                    if (PCSrc) begin
                        w_pc = branch_target;
                    end
                    w_state = ST_FETCH;
                end
            end
            ST_HALT: begin
                w_fetch_q = 1'b0;
                w_instn   = BUBBLE;
                w_valid   = 1'b0;
                w_halted  = 1'b1;
            end
            default: begin
                w_state = ST_FETCH;
            end
        endcase
    end

    assign imem.imem_en   = w_imem_en & rst_n;
    assign imem.imem_addr = r_pc;
    assign instn          = r_instn;
    assign instn_valid    = r_valid;
    assign instn_pc       = r_instn_pc;
    assign halted         = r_halted;

`ifdef IFU_PERF_CNT_EN
    logic [15:0] r_bubble_cnt;
    logic [15:0] r_br_taken_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt   <= 16'd0;
            r_br_taken_cnt <= 16'd0;
        end else begin
            if (!r_valid && (r_state != ST_HALT) && (r_bubble_cnt != 16'hFFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
            if ((r_state == ST_BR_WAIT) && branch_resolved && PCSrc &&
                (r_br_taken_cnt != 16'hFFFF)) begin
                r_br_taken_cnt <= r_br_taken_cnt + 16'd1;
            end
        end
    end

    assign bubble_cnt   = r_bubble_cnt;
    assign br_taken_cnt = r_br_taken_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sources the instruction stream that the decode controller consumes. Owns the PC and drives a synchronous instruction memory.
- Presents one registered 32-bit instruction per cycle and inserts bubbles while a BEQ is unresolved. Redirects the PC on the taken/not-taken result returned by the execute stage.
- Sits between instruction memory and the controller/decoder; it is the producer end of the instn/PCSrc loop.

Parameters:
- ADDR_W, 10, instruction word-address width.
- RESET_PC, 0, PC value after reset.
- BEQ_OPCODE, 6'b000100, opcode that triggers branch wait.
- HALT_OPCODE, 6'b111111, opcode that stops fetching.
- BUBBLE, 32'hF800_0000, bubble instruction; opcode 6'h3E decodes to all-zero controls.

Ports:
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- stall, in, 1, downstream hazard; freezes the fetch pipe.
- imem_en, out, 1, memory read enable.
- imem_addr, out, ADDR_W, memory read address (= pc).
- imem_rdata, in, 32, read data, valid 1 cycle after imem_en; memory holds rdata while imem_en=0.
- branch_resolved, in, 1, execute stage has resolved the pending BEQ.
- PCSrc, in, 1, branch taken (sampled with branch_resolved).
- branch_target, in, ADDR_W, taken target word address.
- instn, out, 32, instruction to controller.
- instn_valid, out, 1, instn is a real instruction.
- instn_pc, out, ADDR_W, word address of instn.
- halted, out, 1, HALT reached.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, fetch_q=0, instn=BUBBLE, instn_valid=0, instn_pc=0, halted=0. imem_en is 0 while in reset.
- Pipeline: cycle t issues imem_en=1, addr=pc, pc<=pc+1, fetch_q<=1, fetch_pc_q<=pc. Cycle t+1 captures imem_rdata into instn. Address-to-instn latency is 2 cycles. PC wraps modulo 2^ADDR_W.
- FETCH state, stall=1: imem_en=0; pc, fetch_q, fetch_pc_q, instn, instn_valid, instn_pc all hold.
- FETCH state, stall=0, fetch_q=1, capture: instn<=imem_rdata, instn_valid<=1, instn_pc<=fetch_pc_q.
  - Captured opcode==BEQ_OPCODE: state<=BR_WAIT, pc<=fetch_pc_q+1. The fetch issued this same cycle is discarded.
  - Captured opcode==HALT_OPCODE: instn<=BUBBLE, instn_valid<=0, state<=HALT, halted<=1.
- FETCH state, stall=0, fetch_q=0: instn<=BUBBLE, instn_valid<=0.
- BR_WAIT: imem_en=0, fetch_q<=0, instn<=BUBBLE, instn_valid<=0 every cycle, regardless of stall.
  - On branch_resolved=1: PCSrc=1 sets pc<=branch_target; PCSrc=0 keeps pc. state<=FETCH.
  - The first post-branch instn appears 2 cycles after resolve.
- branch_resolved in FETCH or HALT is ignored. Only one BEQ is outstanding at a time.
- HALT: imem_en=0, instn=BUBBLE, instn_valid=0, halted=1, held until reset.
- Reset asserted mid-branch or mid-stall returns to the reset state immediately. No pending branch survives reset.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined: adds outputs bubble_cnt[15:0] and br_taken_cnt[15:0].
  - bubble_cnt increments each cycle instn_valid=0 outside HALT.
  - br_taken_cnt increments on branch_resolved&PCSrc in BR_WAIT.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Straight-line fetch: reset, memory words 0..3 = ADDI encodings, stall=0 -> instn_valid=1 from cycle 2 after reset release, instn_pc=0,1,2,3 on consecutive cycles.
- Stall hold: assert stall for 3 cycles while instn_pc=1 -> instn, instn_pc=1 and imem_addr frozen. Release -> instn_pc=2 next cycle, no word skipped or duplicated.
- BEQ not taken: BEQ at word 4, branch_resolved&!PCSrc after 3 cycles -> BUBBLE/instn_valid=0 during wait, then instn_pc=5 two cycles after resolve.
- BEQ taken: BEQ at 4, resolve with PCSrc=1, branch_target=20 -> next valid instn_pc=20. Word 5 is never presented valid.
- HALT and wrap: HALT at word 7 -> halted=1, imem_en=0 forever. Separately, ADDR_W=4 run from 14 -> instn_pc sequence 14,15,0,1.
- Async reset inside BR_WAIT: drop rst_n between clock edges -> outputs at reset values immediately. After release, fetch restarts at RESET_PC with no stale redirect.
